// File: rtl/attn_scorer.sv
// Attention scorer: per-row dot-product logits, shift-based base-2 softmax and
// serial restoring division, producing one unsigned Q0.FRAC_W weight per key row.
module attn_scorer #(
   parameter int SEQ_LEN  = 3,
   parameter int HEAD_DIM = 2,
   parameter int DW       = 4,
   parameter int FRAC_W   = 4,
   parameter int TSHIFT   = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic signed [DW-1:0]     q     [HEAD_DIM],
   input  logic signed [DW-1:0]     k_mat [SEQ_LEN][HEAD_DIM],
   output logic                     busy,
   output logic                     out_valid,
   output logic        [FRAC_W-1:0] score [SEQ_LEN]
);

   localparam int LW = 2*DW + $clog2(HEAD_DIM);
   localparam int SW = FRAC_W + 1 + $clog2(SEQ_LEN);
   localparam int RW = SW + 1;
   localparam int IW = $clog2(SEQ_LEN);
   localparam int BW = $clog2(FRAC_W + 1);

   localparam logic [IW-1:0]   LAST_ROW = IW'(SEQ_LEN - 1);
   localparam logic [BW-1:0]   LAST_BIT = BW'(FRAC_W);
   localparam logic [LW:0]     D_LIM    = (LW+1)'(FRAC_W);
   localparam logic [FRAC_W:0] E_ONE    = (FRAC_W+1)'(1) << FRAC_W;

   typedef enum logic [2:0] {IDLE, DOT, EXP, DIV, DONE} state_t;

   state_t state, state_n;

   logic signed [DW-1:0]     q_r     [HEAD_DIM];
   logic signed [DW-1:0]     k_r     [SEQ_LEN][HEAD_DIM];
   logic signed [LW-1:0]     logit_r [SEQ_LEN];
   logic        [FRAC_W:0]   e_r     [SEQ_LEN];
   logic        [FRAC_W-1:0] stage   [SEQ_LEN];
   logic signed [LW-1:0]     max_r;
   logic        [SW-1:0]     sum_r;
   logic        [RW-1:0]     rem_r;
   logic        [FRAC_W-1:0] quot_r;
   logic        [IW-1:0]     idx;
   logic        [BW-1:0]     bit_cnt;

   logic signed [LW-1:0]     logit_c;
   logic signed [LW:0]       diff_c;
   logic        [LW:0]       d_c;
   logic        [FRAC_W:0]   e_c;
   logic        [RW-1:0]     cur_c;
   logic        [RW-1:0]     rem_c;
   logic                     ge_c;
   logic        [FRAC_W:0]   quot_c;

   // 2^-d in Q1.FRAC_W; anything shifted past the last fraction bit is zero
   function automatic logic [FRAC_W:0] exp2_neg(input logic [LW:0] d);
      if (d > D_LIM) return '0;
      return E_ONE >> d;
   endfunction

   // Only a lone dominant row can reach 1.0 exactly; clamp it to the largest code
   function automatic logic [FRAC_W-1:0] sat_quot(input logic [FRAC_W:0] v);
      if (v[FRAC_W]) return '1;
      return v[FRAC_W-1:0];
   endfunction

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start) state_n = DOT;
         DOT:     if (idx == LAST_ROW) state_n = EXP;
         EXP:     if (idx == LAST_ROW) state_n = DIV;
         DIV:     if (idx == LAST_ROW && bit_cnt == LAST_BIT) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      logit_c = '0;
      for (int h = 0; h < HEAD_DIM; h++) begin
         logit_c = logit_c + LW'((2*DW)'(q_r[h]) * (2*DW)'(k_r[idx][h]));
      end
      diff_c = (LW+1)'(max_r) - (LW+1)'(logit_r[idx]);
      d_c    = $unsigned(diff_c) >> TSHIFT;
      e_c    = exp2_neg(d_c);
      // First quotient bit of a row starts from e itself (dividend is e << FRAC_W)
      cur_c  = (bit_cnt == '0) ? RW'(e_r[idx]) : rem_r;
      ge_c   = (cur_c >= RW'(sum_r));
      rem_c  = ge_c ? (cur_c - RW'(sum_r)) : cur_c;
      quot_c = {quot_r, ge_c};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy      <= 1'b0;
         out_valid <= 1'b0;
         idx       <= '0;
         bit_cnt   <= '0;
         max_r     <= '0;
         sum_r     <= '0;
         rem_r     <= '0;
         quot_r    <= '0;
         for (int h = 0; h < HEAD_DIM; h++) q_r[h] <= '0;
         for (int i = 0; i < SEQ_LEN; i++) begin
            for (int h = 0; h < HEAD_DIM; h++) k_r[i][h] <= '0;
            logit_r[i] <= '0;
            e_r[i]     <= '0;
            stage[i]   <= '0;
            score[i]   <= '0;
         end
      end else begin
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  busy    <= 1'b1;
                  idx     <= '0;
                  bit_cnt <= '0;
                  q_r     <= q;
                  k_r     <= k_mat;
               end
            end
            DOT: begin
               logit_r[idx] <= logit_c;
               if (idx == '0 || logit_c > max_r) max_r <= logit_c;
               idx <= (idx == LAST_ROW) ? '0 : idx + 1'b1;
            end
            EXP: begin
               e_r[idx] <= e_c;
               sum_r    <= ((idx == '0) ? '0 : sum_r) + SW'(e_c);
               idx      <= (idx == LAST_ROW) ? '0 : idx + 1'b1;
            end
            DIV: begin
               quot_r <= quot_c[FRAC_W-1:0];
               rem_r  <= rem_c << 1;
               if (bit_cnt == LAST_BIT) begin
                  stage[idx] <= sat_quot(quot_c);
                  bit_cnt    <= '0;
                  idx        <= (idx == LAST_ROW) ? '0 : idx + 1'b1;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            DONE: begin
               for (int i = 0; i < SEQ_LEN; i++) score[i] <= stage[i];
               out_valid <= 1'b1;
               busy      <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_attn_scorer.sv
// Scoreboard bench for attn_scorer: two instances (TSHIFT 0 and 3) share stimulus;
// expected weights come from an integer softmax model queued at each accepted start.
module tb_attn_scorer;

   localparam int SEQ = 3;
   localparam int HD  = 2;
   localparam int F   = 4;
   localparam int LAT = 22;

   logic clk = 1'b0;
   logic rst, start;
   logic signed [3:0] q     [HD];
   logic signed [3:0] k_mat [SEQ][HD];
   logic busy, out_valid, busy3, ov3;
   logic [F-1:0] score  [SEQ];
   logic [F-1:0] score3 [SEQ];

   int cyc = 0;
   int total = 0;
   int bad = 0;

   typedef struct packed {
      int                    due;
      logic [SEQ-1:0][F-1:0] s;
   } exp_t;

   exp_t sb_main[$];
   exp_t sb_t3[$];

   attn_scorer #(.SEQ_LEN(SEQ), .HEAD_DIM(HD), .DW(4), .FRAC_W(F), .TSHIFT(0)) dut (
      .clk(clk), .rst(rst), .start(start), .q(q), .k_mat(k_mat),
      .busy(busy), .out_valid(out_valid), .score(score));

   attn_scorer #(.SEQ_LEN(SEQ), .HEAD_DIM(HD), .DW(4), .FRAC_W(F), .TSHIFT(3)) dut_t3 (
      .clk(clk), .rst(rst), .start(start), .q(q), .k_mat(k_mat),
      .busy(busy3), .out_valid(ov3), .score(score3));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [SEQ-1:0][F-1:0] model(input int tsh);
      int lg[SEQ];
      int e[SEQ];
      int mx, d, sum, qt;
      logic [SEQ-1:0][F-1:0] r;
      for (int i = 0; i < SEQ; i++) begin
         lg[i] = 0;
         for (int h = 0; h < HD; h++) lg[i] += int'(q[h]) * int'(k_mat[i][h]);
      end
      mx = lg[0];
      for (int i = 1; i < SEQ; i++) if (lg[i] > mx) mx = lg[i];
      sum = 0;
      for (int i = 0; i < SEQ; i++) begin
         d    = (mx - lg[i]) >>> tsh;
         e[i] = (d > F) ? 0 : ((1 << F) >> d);
         sum += e[i];
      end
      for (int i = 0; i < SEQ; i++) begin
         qt = (e[i] << F) / sum;
         if (qt > (1 << F) - 1) qt = (1 << F) - 1;
         r[i] = F'(qt);
      end
      return r;
   endfunction

   task automatic set_in(input int q0, input int q1, input int k00, input int k01,
                         input int k10, input int k11, input int k20, input int k21);
      q[0] = 4'(q0);         q[1] = 4'(q1);
      k_mat[0][0] = 4'(k00); k_mat[0][1] = 4'(k01);
      k_mat[1][0] = 4'(k10); k_mat[1][1] = 4'(k11);
      k_mat[2][0] = 4'(k20); k_mat[2][1] = 4'(k21);
   endtask

   task automatic kick(input bit accept);
      exp_t x;
      start = 1'b1;
      if (accept) begin
         x.due = cyc + LAT + 1;
         x.s   = model(0);
         sb_main.push_back(x);
         x.s   = model(3);
         sb_t3.push_back(x);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int h = 0; h < HD; h++) q[h] = 4'($urandom);
      for (int i = 0; i < SEQ; i++)
         for (int h = 0; h < HD; h++) k_mat[i][h] = 4'($urandom);
   endtask

   task automatic wait_ov(input string tag);
      bit seen = 1'b0;
      for (int n = 0; n < 40 && !seen; n++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      if (!seen) chk({tag, "_timeout"}, 0, 1);
   endtask

   task automatic chk_sc(input string tag, input int a, input int b, input int c);
      chk({tag, "_s0"}, int'(score[0]), a);
      chk({tag, "_s1"}, int'(score[1]), b);
      chk({tag, "_s2"}, int'(score[2]), c);
   endtask

   task automatic chk_sc3(input string tag, input int a, input int b, input int c);
      chk({tag, "_t3_s0"}, int'(score3[0]), a);
      chk({tag, "_t3_s1"}, int'(score3[1]), b);
      chk({tag, "_t3_s2"}, int'(score3[2]), c);
   endtask

   always @(negedge clk) begin
      exp_t x;
      if (out_valid) begin
         if (sb_main.size() == 0) chk("main_unexp_ov", 1, 0);
         else begin
            x = sb_main.pop_front();
            chk("main_lat", cyc, x.due);
            for (int i = 0; i < SEQ; i++) chk("main_sb", int'(score[i]), int'(x.s[i]));
         end
      end else if (sb_main.size() != 0 && cyc > sb_main[0].due) begin
         chk("main_late", cyc, sb_main[0].due);
         void'(sb_main.pop_front());
      end
   end

   always @(negedge clk) begin
      exp_t x;
      if (ov3) begin
         if (sb_t3.size() == 0) chk("t3_unexp_ov", 1, 0);
         else begin
            x = sb_t3.pop_front();
            chk("t3_lat", cyc, x.due);
            for (int i = 0; i < SEQ; i++) chk("t3_sb", int'(score3[i]), int'(x.s[i]));
         end
      end else if (sb_t3.size() != 0 && cyc > sb_t3[0].due) begin
         chk("t3_late", cyc, sb_t3[0].due);
         void'(sb_t3.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "bench did not terminate");
   end

   initial begin
      int ovs;
      rst   = 1'b1;
      start = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_ov", int'(out_valid), 0);
      chk_sc("rst", 0, 0, 0);
      chk_sc3("rst", 0, 0, 0);

      // Basic ramp with busy window and single-cycle out_valid
      set_in(1, 0, 3, 0, 2, 0, 1, 0);
      kick(1'b1);
      for (int n = 0; n < LAT - 1; n++) begin
         @(negedge clk);
         chk("a_busy", int'(busy), 1);
      end
      wait_ov("a");
      chk("a_busy_ov", int'(busy), 0);
      chk_sc("a", 9, 4, 2);
      chk_sc3("a", 5, 5, 5);
      @(negedge clk);
      chk("a_pulse", int'(out_valid), 0);
      chk_sc("a_hold", 9, 4, 2);

      // All-zero query
      set_in(0, 0, 5, -3, -8, 7, 2, 2);
      kick(1'b1);
      wait_ov("b");
      chk_sc("b", 5, 5, 5);
      chk_sc3("b", 5, 5, 5);

      // Dominant row with saturation
      set_in(7, 7, 7, 7, -8, -8, 0, 0);
      kick(1'b1);
      wait_ov("c");
      chk_sc("c", 15, 0, 0);
      chk_sc3("c", 15, 0, 0);

      // Extreme operand widths, temperature shift on the second instance
      set_in(-8, -8, -8, -8, -8, -7, 7, 7);
      kick(1'b1);
      wait_ov("d");
      chk_sc("d", 15, 0, 0);
      chk_sc3("d", 10, 5, 0);

      // Start while busy is ignored
      set_in(1, 0, 3, 0, 2, 0, 1, 0);
      kick(1'b1);
      repeat (4) @(posedge clk);
      #1;
      set_in(-8, -8, -8, -8, -8, -7, 7, 7);
      kick(1'b0);
      wait_ov("ign");
      chk_sc("ign", 9, 4, 2);
      chk_sc3("ign", 5, 5, 5);

      // Mid-run reset aborts and clears
      set_in(-8, -8, -8, -8, -8, -7, 7, 7);
      kick(1'b1);
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b1;
      sb_main.delete();
      sb_t3.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_busy", int'(busy), 0);
      chk("abort_ov", int'(out_valid), 0);
      chk_sc("abort", 0, 0, 0);
      chk_sc3("abort", 0, 0, 0);
      ovs = 0;
      repeat (30) begin
         @(negedge clk);
         ovs += int'(out_valid) + int'(ov3);
      end
      chk("abort_quiet", ovs, 0);

      // Fresh run after abort
      set_in(2, -1, 1, 1, 3, -2, -4, 0);
      kick(1'b1);
      wait_ov("fresh");
      chk_sc("fresh", 0, 15, 0);
      chk_sc3("fresh", 7, 7, 1);

      // Back-to-back: new start in the out_valid cycle, old score held meanwhile
      set_in(7, 7, 7, 7, -8, -8, 0, 0);
      kick(1'b1);
      wait_ov("bb1");
      chk("bb1_busy", int'(busy), 0);
      set_in(1, 0, 3, 0, 2, 0, 1, 0);
      kick(1'b1);
      repeat (10) @(negedge clk);
      chk("bb_mid_busy", int'(busy), 1);
      chk_sc("bb_hold", 15, 0, 0);
      chk_sc3("bb_hold", 15, 0, 0);
      wait_ov("bb2");
      chk_sc("bb2", 9, 4, 2);
      chk_sc3("bb2", 5, 5, 5);

      repeat (3) @(negedge clk);
      chk("sb_empty", sb_main.size() + sb_t3.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/attn_scorer.md
Name: attn_scorer

Overview:
Upstream producer of attention weights for the attention reader stage. It takes a query vector and a key matrix, computes one dot-product logit per sequence position, and applies a shift-based base-2 softmax approximation. It then normalises by serial division and emits one unsigned Q0.FRAC_W score per position. Its score and out_valid outputs connect directly to the reader's score and start inputs.

Parameters:
SEQ_LEN, 3, number of key rows (sequence positions); must be at least 2
HEAD_DIM, 2, vector length of q and of each key row
DW, 4, bitwidth of q and k_mat elements (signed)
FRAC_W, 4, fractional bits of output score (unsigned Q0.FRAC_W)
TSHIFT, 0, arithmetic right shift applied to logit distance before exponent (temperature)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  single-cycle request; accepted only when busy=0
q  in  signed [DW-1:0] x HEAD_DIM  query vector
k_mat  in  signed [DW-1:0] x SEQ_LEN x HEAD_DIM  key matrix
busy  out  1  high from the cycle after start is accepted up to, but not including, the out_valid cycle
out_valid  out  1  one-cycle pulse; score is valid and held from this cycle on
score  out  [FRAC_W-1:0] x SEQ_LEN  normalised weights, held until the next out_valid

Behaviour:
- Reset: busy=0, out_valid=0, all score=0, FSM=IDLE, internal registers cleared. rst overrides start in the same cycle.
- rst asserted mid-operation: abort immediately and return to IDLE with the reset values above. No out_valid is produced for the aborted run.
- Capture: on an accepted start, q and k_mat are registered. Inputs may change freely afterwards.
- start while busy=1: ignored, with no effect on the run in progress.
- FSM states: IDLE, DOT, EXP, DIV, DONE.
- IDLE -> DOT on an accepted start.
- DOT: SEQ_LEN cycles, one row i per cycle.
  - logit[i] = sum over h of q[h]*k[i][h], computed with all h in parallel.
  - Logit width LW = 2*DW+$clog2(HEAD_DIM), signed, full precision, no overflow.
  - A running signed max is tracked; on ties the value is the same, so no tie rule is needed.
- EXP: SEQ_LEN cycles, one row per cycle.
  - d = (max - logit[i]) >> TSHIFT, unsigned, width LW+1.
  - e[i] = (d > FRAC_W) ? 0 : (2^FRAC_W >> d). e is FRAC_W+1 bits.
  - sum += e[i]. Sum width is FRAC_W+1+$clog2(SEQ_LEN).
  - sum >= 2^FRAC_W is guaranteed, because the max row gives d=0.
- DIV: FRAC_W+1 cycles per row, SEQ_LEN rows, rows processed in order.
  - Restoring division gives quot = floor(e[i]*2^FRAC_W / sum), one quotient bit per cycle, MSB first.
  - quot can reach 2^FRAC_W. Saturate it to 2^FRAC_W-1 and store it in an internal staging register.
- DONE: one cycle.
  - Copy the staging registers to score, pulse out_valid=1, drop busy=0, return to IDLE.
  - A start in the DONE cycle is accepted and begins a new run.
  - The old score values stay held until the new run's DONE.
- Latency: out_valid is high on the L-th rising edge after the edge that samples start, where L = SEQ_LEN*(FRAC_W+3)+1. With default parameters L = 22.
- score never changes except in the DONE cycle or on reset.

Test Plan:
- Defaults, q=(1,0), k rows (3,0),(2,0),(1,0) -> logits 3,2,1; e=16,8,4; sum 28; score=(9,4,2). out_valid exactly 22 cycles after start; busy high for the 21 cycles between.
- q=(0,0), any k -> all logits 0; e=16 each; sum 48; score=(5,5,5).
- Dominant row plus saturation: q=(7,7), k rows (7,7),(-8,-8),(0,0) -> logits 98,-112,0; e=16,0,0; quot 16 saturates; score=(15,0,0).
- Extreme widths: q=(-8,-8), k rows (-8,-8),(-8,-7),(7,7) -> logits 128,120,-112 with no overflow; score=(15,0,0).
  - Same inputs with TSHIFT=3 -> d=0,1,30; e=16,8,0; sum 24; score=(10,5,0).
- Control: start pulsed again at cycle 5 -> ignored, result unchanged.
  - rst at cycle 8 -> busy=0, out_valid=0, score=0 next cycle.
  - A fresh start afterwards completes normally after 22 cycles.
- Back-to-back: start asserted in the DONE cycle with new inputs -> accepted. The first score holds until the second out_valid, 22 cycles later.
